// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID-stage decode inputs and hazard control outputs
interface pipe_hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_wreg;
    logic       id_m2reg;
    logic [4:0] id_rn;
    logic       id_mdu;
    logic       id_btaken;
    logic [1:0] id_adepen;
    logic [1:0] id_bdepen;
    logic       stall;
    logic       bubble;
    logic       flush_ifid;
    logic       mdu_busy;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg,
               id_m2reg, id_rn, id_mdu, id_btaken,
        input  id_adepen, id_bdepen, stall, bubble, flush_ifid, mdu_busy
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg,
               id_m2reg, id_rn, id_mdu, id_btaken,
        output id_adepen, id_bdepen, stall, bubble, flush_ifid, mdu_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - forwarding, load-use and MDU stall control for the ID/EXE register
module pipe_hazard_ctrl #(
    parameter int unsigned MDU_CYCLES = 4
) (
    input  logic               clk,
    input  logic               clrn,
    pipe_hazard_ctrl_if.slave  hz
);
    typedef enum logic {RUN, MDU_BUSY} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MDU_CYCLES - 2);

    state_t     state;
    logic [3:0] count;

    logic       ex_valid, ex_wreg, ex_m2reg;
    logic [4:0] ex_rn;
    logic       mem_valid, mem_wreg, mem_m2reg;
    logic [4:0] mem_rn;

    logic       ex_a, ex_b, mem_a, mem_b;
    logic       lu, releasing, issue;
    logic       stall_i, bubble_i, flush_i;
    logic [1:0] adepen_i, bdepen_i;

    function automatic logic hit(input logic use_f, input logic v, input logic w,
                                 input logic [4:0] rn, input logic [4:0] src);
        return use_f & v & w & (rn == src) & (src != 5'd0);
    endfunction

    // An EXE hit on a load cannot be forwarded yet; the load-use stall covers it.
    function automatic logic [1:0] sel(input logic exh, input logic exld,
                                       input logic memh, input logic memld);
        if (exh)       return exld ? 2'b00 : 2'b01;
        else if (memh) return memld ? 2'b11 : 2'b10;
        else           return 2'b00;
    endfunction

    always_comb begin
        ex_a     = hit(hz.id_use_rs, ex_valid,  ex_wreg,  ex_rn,  hz.id_rs);
        ex_b     = hit(hz.id_use_rt, ex_valid,  ex_wreg,  ex_rn,  hz.id_rt);
        mem_a    = hit(hz.id_use_rs, mem_valid, mem_wreg, mem_rn, hz.id_rs);
        mem_b    = hit(hz.id_use_rt, mem_valid, mem_wreg, mem_rn, hz.id_rt);
        adepen_i = sel(ex_a, ex_m2reg, mem_a, mem_m2reg);
        bdepen_i = sel(ex_b, ex_m2reg, mem_b, mem_m2reg);
        lu       = hz.id_valid & (ex_a | ex_b) & ex_m2reg;
        // The last MDU_BUSY cycle (count 0) releases the pipe and decodes ID as in RUN.
        releasing = (state == RUN) | (count == 4'd0);
        issue     = releasing & ~lu & hz.id_valid & hz.id_mdu;
        stall_i   = ~releasing | lu | issue;
        bubble_i  = ~releasing | lu;
        flush_i   = releasing & ~lu & ~issue & hz.id_valid & hz.id_btaken;
    end

    assign hz.id_adepen  = clrn ? adepen_i : 2'b00;
    assign hz.id_bdepen  = clrn ? bdepen_i : 2'b00;
    assign hz.stall      = clrn & stall_i;
    assign hz.bubble     = ~clrn | bubble_i;
    assign hz.flush_ifid = ~clrn | flush_i;
    assign hz.mdu_busy   = clrn & ~releasing;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state     <= RUN;
            count     <= 4'd0;
            ex_valid  <= 1'b0;
            ex_wreg   <= 1'b0;
            ex_m2reg  <= 1'b0;
            ex_rn     <= 5'd0;
            mem_valid <= 1'b0;
            mem_wreg  <= 1'b0;
            mem_m2reg <= 1'b0;
            mem_rn    <= 5'd0;
        end else begin
            mem_valid <= ex_valid;
            mem_wreg  <= ex_wreg;
            mem_m2reg <= ex_m2reg;
            mem_rn    <= ex_rn;
            if (bubble_i) begin
                ex_valid <= 1'b0;
                ex_wreg  <= 1'b0;
                ex_m2reg <= 1'b0;
                ex_rn    <= 5'd0;
            end else begin
                ex_valid <= hz.id_valid;
                ex_wreg  <= hz.id_wreg;
                ex_m2reg <= hz.id_m2reg;
                ex_rn    <= hz.id_rn;
            end
            if (issue) begin
                state <= MDU_BUSY;
                count <= CNT_INIT;
            end else if (state == MDU_BUSY) begin
                if (count != 4'd0) count <= count - 4'd1;
                else               state <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed-vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic clrn;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.MDU_CYCLES(4)) dut (
        .clk  (clk),
        .clrn (clrn),
        .hz   (hz)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic w, input logic m,
                          input logic [4:0] rn, input logic mdu, input logic bt);
        hz.id_valid  = v;   hz.id_rs     = rs;  hz.id_rt   = rt;
        hz.id_use_rs = urs; hz.id_use_rt = urt; hz.id_wreg = w;
        hz.id_m2reg  = m;   hz.id_rn     = rn;  hz.id_mdu  = mdu;
        hz.id_btaken = bt;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        clrn = 1'b1;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        set_id(1, 3, 3, 1, 1, 1, 0, 3, 1, 1);
        tick(); tick();
        #1;
        total++; if (hz.stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", hz.stall); else passed++;
        total++; if (hz.bubble !== 1'b1) $display("FAIL rst_bubble got %b exp 1", hz.bubble); else passed++;
        total++; if (hz.flush_ifid !== 1'b1) $display("FAIL rst_flush got %b exp 1", hz.flush_ifid); else passed++;
        total++; if (hz.mdu_busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", hz.mdu_busy); else passed++;
        total++; if (hz.id_adepen !== 2'b00) $display("FAIL rst_adepen got %b exp 00", hz.id_adepen); else passed++;
        clrn = 1'b1;
        set_id(1, 3, 3, 1, 1, 0, 0, 0, 0, 0);
        #1;
        total++; if (hz.id_adepen !== 2'b00) $display("FAIL post_rst_adepen got %b exp 00", hz.id_adepen); else passed++;
        total++; if (hz.id_bdepen !== 2'b00) $display("FAIL post_rst_bdepen got %b exp 00", hz.id_bdepen); else passed++;
        total++; if (hz.stall !== 1'b0) $display("FAIL post_rst_stall got %b exp 0", hz.stall); else passed++;
        total++; if (hz.bubble !== 1'b0) $display("FAIL post_rst_bubble got %b exp 0", hz.bubble); else passed++;
    endtask

    task automatic test_forward();
        do_reset();
        set_id(1, 1, 2, 1, 1, 1, 0, 3, 0, 0);          // add r3,r1,r2
        #1;
        total++; if (hz.stall !== 1'b0) $display("FAIL fwd_add_stall got %b exp 0", hz.stall); else passed++;
        tick();
        set_id(1, 3, 1, 1, 1, 1, 0, 4, 0, 0);          // sub r4,r3,r1
        #1;
        total++; if (hz.id_adepen !== 2'b01) $display("FAIL fwd_sub_adepen got %b exp 01", hz.id_adepen); else passed++;
        total++; if (hz.id_bdepen !== 2'b00) $display("FAIL fwd_sub_bdepen got %b exp 00", hz.id_bdepen); else passed++;
        total++; if (hz.stall !== 1'b0) $display("FAIL fwd_sub_stall got %b exp 0", hz.stall); else passed++;
        tick();
        set_id(1, 3, 0, 1, 1, 1, 0, 5, 0, 0);          // or r5,r3,r0
        #1;
        total++; if (hz.id_adepen !== 2'b10) $display("FAIL fwd_or_adepen got %b exp 10", hz.id_adepen); else passed++;
        total++; if (hz.id_bdepen !== 2'b00) $display("FAIL fwd_or_bdepen got %b exp 00", hz.id_bdepen); else passed++;
        tick();
        set_id(1, 4, 5, 1, 1, 0, 0, 0, 0, 0);          // reads r4 (MEM) and r5 (EXE)
        #1;
        total++; if (hz.id_adepen !== 2'b10) $display("FAIL fwd_mix_adepen got %b exp 10", hz.id_adepen); else passed++;
        total++; if (hz.id_bdepen !== 2'b01) $display("FAIL fwd_mix_bdepen got %b exp 01", hz.id_bdepen); else passed++;
        set_id(1, 4, 5, 0, 0, 0, 0, 0, 0, 0);          // same regs, use flags off
        #1;
        total++; if (hz.id_bdepen !== 2'b00) $display("FAIL fwd_nouse_bdepen got %b exp 00", hz.id_bdepen); else passed++;
    endtask

    task automatic test_load_use(input logic bt);
        do_reset();
        set_id(1, 0, 0, 0, 0, 1, 1, 2, 0, 0);          // lw r2
        #1;
        total++; if (hz.stall !== 1'b0) $display("FAIL lu_lw_stall got %b exp 0", hz.stall); else passed++;
        tick();
        set_id(1, 2, 2, 1, 1, 1, 0, 6, 0, bt);         // add r6,r2,r2 (maybe a taken branch)
        #1;
        total++; if (hz.stall !== 1'b1) $display("FAIL lu_stall got %b exp 1", hz.stall); else passed++;
        total++; if (hz.bubble !== 1'b1) $display("FAIL lu_bubble got %b exp 1", hz.bubble); else passed++;
        total++; if (hz.flush_ifid !== 1'b0) $display("FAIL lu_flush got %b exp 0", hz.flush_ifid); else passed++;
        tick();
        #1;
        total++; if (hz.stall !== 1'b0) $display("FAIL lu_rel_stall got %b exp 0", hz.stall); else passed++;
        total++; if (hz.id_adepen !== 2'b11) $display("FAIL lu_rel_adepen got %b exp 11", hz.id_adepen); else passed++;
        total++; if (hz.id_bdepen !== 2'b11) $display("FAIL lu_rel_bdepen got %b exp 11", hz.id_bdepen); else passed++;
        total++; if (hz.flush_ifid !== bt) $display("FAIL lu_rel_flush got %b exp %b", hz.flush_ifid, bt); else passed++;
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (hz.flush_ifid !== 1'b0) $display("FAIL lu_after_flush got %b exp 0", hz.flush_ifid); else passed++;
    endtask

    task automatic test_mdu();
        logic [2:0] exp_stall;
        logic [2:0] exp_busy;
        exp_stall = 3'b111;
        exp_busy  = 3'b110;
        do_reset();
        set_id(1, 1, 2, 1, 1, 1, 0, 7, 1, 0);          // mult into r7
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (hz.stall !== exp_stall[i]) $display("FAIL mdu_stall%0d got %b exp %b", i, hz.stall, exp_stall[i]); else passed++;
            total++; if (hz.mdu_busy !== exp_busy[i]) $display("FAIL mdu_busy%0d got %b exp %b", i, hz.mdu_busy, exp_busy[i]); else passed++;
            total++; if (hz.bubble !== exp_busy[i]) $display("FAIL mdu_bubble%0d got %b exp %b", i, hz.bubble, exp_busy[i]); else passed++;
            tick();
            set_id(1, 1, 2, 1, 1, 1, 0, 8, 0, 0);      // independent add r8
        end
        #1;
        total++; if (hz.stall !== 1'b0) $display("FAIL mdu_done_stall got %b exp 0", hz.stall); else passed++;
        total++; if (hz.mdu_busy !== 1'b0) $display("FAIL mdu_done_busy got %b exp 0", hz.mdu_busy); else passed++;
        total++; if (hz.bubble !== 1'b0) $display("FAIL mdu_done_bubble got %b exp 0", hz.bubble); else passed++;
        tick();
        set_id(1, 1, 2, 1, 1, 1, 0, 9, 1, 0);          // second MDU op
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++; if (hz.mdu_busy !== 1'b1) $display("FAIL mdu2_busy got %b exp 1", hz.mdu_busy); else passed++;
        clrn = 1'b0;
        #1;
        total++; if (hz.stall !== 1'b0) $display("FAIL mdu_rst_stall got %b exp 0", hz.stall); else passed++;
        total++; if (hz.mdu_busy !== 1'b0) $display("FAIL mdu_rst_busy got %b exp 0", hz.mdu_busy); else passed++;
        tick();
        clrn = 1'b1;
        #1;
        total++; if (hz.stall !== 1'b0) $display("FAIL mdu_abort_stall got %b exp 0", hz.stall); else passed++;
        total++; if (hz.mdu_busy !== 1'b0) $display("FAIL mdu_abort_busy got %b exp 0", hz.mdu_busy); else passed++;
    endtask

    task automatic test_r0();
        do_reset();
        set_id(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);          // lw r0
        tick();
        set_id(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);          // add r0,r0,r0
        #1;
        total++; if (hz.id_adepen !== 2'b00) $display("FAIL r0_ex_adepen got %b exp 00", hz.id_adepen); else passed++;
        total++; if (hz.stall !== 1'b0) $display("FAIL r0_ex_stall got %b exp 0", hz.stall); else passed++;
        tick();
        set_id(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        #1;
        total++; if (hz.id_adepen !== 2'b00) $display("FAIL r0_mem_adepen got %b exp 00", hz.id_adepen); else passed++;
        total++; if (hz.id_bdepen !== 2'b00) $display("FAIL r0_mem_bdepen got %b exp 00", hz.id_bdepen); else passed++;
        total++; if (hz.stall !== 1'b0) $display("FAIL r0_mem_stall got %b exp 0", hz.stall); else passed++;
        tick();
        set_id(1, 0, 0, 0, 0, 1, 1, 9, 0, 0);          // lw r9
        tick();
        set_id(0, 9, 9, 1, 1, 0, 0, 0, 1, 1);          // invalid slot reading r9
        #1;
        total++; if (hz.stall !== 1'b0) $display("FAIL inv_stall got %b exp 0", hz.stall); else passed++;
        total++; if (hz.flush_ifid !== 1'b0) $display("FAIL inv_flush got %b exp 0", hz.flush_ifid); else passed++;
    endtask

    initial begin
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clrn = 1'b0;
        test_reset();
        test_forward();
        test_load_use(1'b0);
        test_load_use(1'b1);
        test_mdu();
        test_r0();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
